// File: rtl/zbb_pkg.sv
// Zbb execute unit shared definitions: opcodes, operand-select codes, clmul FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zbb_pkg;

  // Opcode encoding carried on alu_op_i
  localparam logic [4:0] OP_NOP    = 5'h00;
  localparam logic [4:0] OP_CLZ    = 5'h01;
  localparam logic [4:0] OP_CTZ    = 5'h02;
  localparam logic [4:0] OP_CPOP   = 5'h03;
  localparam logic [4:0] OP_MINU   = 5'h04;
  localparam logic [4:0] OP_MAXU   = 5'h05;
  localparam logic [4:0] OP_SEXTH  = 5'h06;
  localparam logic [4:0] OP_SEXTB  = 5'h07;
  localparam logic [4:0] OP_MAX    = 5'h08;
  localparam logic [4:0] OP_MIN    = 5'h09;
  localparam logic [4:0] OP_ZEXTH  = 5'h0A;
  localparam logic [4:0] OP_ROL    = 5'h0B;
  localparam logic [4:0] OP_ROR    = 5'h0C;
  localparam logic [4:0] OP_ORCB   = 5'h0E;
  localparam logic [4:0] OP_REV8   = 5'h0F;
  localparam logic [4:0] OP_ANDN   = 5'h10;
  localparam logic [4:0] OP_ORN    = 5'h11;
  localparam logic [4:0] OP_XNOR   = 5'h12;
  localparam logic [4:0] OP_CLMUL  = 5'h13;
  localparam logic [4:0] OP_CLMULH = 5'h14;
  localparam logic [4:0] OP_CLMULR = 5'h15;

  // Operand select codes for mux1_i / mux2_i
  localparam logic [1:0] SEL_RS    = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_ZERO  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } clmul_st_e;

  function automatic logic is_clmul(input logic [4:0] op);
    return (op == OP_CLMUL) || (op == OP_CLMULH) || (op == OP_CLMULR);
  endfunction

endpackage

// File: rtl/zbb_clmul_iter.sv
// Iterative carry-less multiplier: consumes STEP bits of op2 (LSB first) per RUN cycle.
// Latency: 1 load edge + XLEN/STEP RUN edges, then holds DONE until i_ack.
// Backpressure: DONE state (and o_prod) held until the consumer raises i_ack.
// Ports: clk_25mhz/rst clock and sync reset; i_start loads i_op1/i_op2 when idle;
//        i_ack releases DONE; o_done/o_busy status; o_prod 2*XLEN product.
module zbb_clmul_iter
  import zbb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic              clk_25mhz,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_ack,
  input  logic [XLEN-1:0]   i_op1,
  input  logic [XLEN-1:0]   i_op2,
  output logic              o_done,
  output logic              o_busy,
  output logic [2*XLEN-1:0] o_prod
);

  localparam int NCYC = XLEN / STEP;
  localparam int CW   = $clog2(NCYC + 1);

  clmul_st_e           r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_a;
  logic [XLEN-1:0]     r_b;
  logic [2*XLEN-1:0]   r_acc;
  logic [2*XLEN-1:0]   w_acc_nxt;
  logic                w_last;

  assign w_last = (r_cnt == CW'(NCYC - 1));

  always_ff @(posedge clk_25mhz) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)  w_state_nxt = ST_DONE;
      ST_DONE: if (i_ack)   w_state_nxt = ST_IDLE;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_done = (r_state == ST_DONE);
    o_busy = (r_state != ST_IDLE);
    o_prod = r_acc;
  end

  // r_a is op1 pre-shifted by the bits already consumed, so each partial
  // product only needs the small in-step shift j.
  always_comb begin
    w_acc_nxt = r_acc;
    for (int j = 0; j < STEP; j++) begin
      if (r_b[j]) w_acc_nxt = w_acc_nxt ^ (r_a << j);
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_cnt <= '0;
      r_a   <= {{XLEN{1'b0}}, i_op1};
      r_b   <= i_op2;
      r_acc <= '0;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_a   <= r_a << STEP;
      r_b   <= r_b >> STEP;
      r_acc <= w_acc_nxt;
    end
  end

endmodule

// File: rtl/zbb_exec_pipe.sv
// Zbb execute stage: operand forwarding muxes, S1 operand register, Zbb ALU, output register.
// Latency: 2 edges for single-cycle ops; clmul (ZBB_CLMUL_EN) XLEN/CLMUL_STEP+2 edges.
// Backpressure: valid/ready; output held while out_ready_i low, in_ready_o drops when S1 cannot drain.
// Ports: clk_25mhz/rst; in_valid_i/in_ready_o, alu_op_i, rs1_i/rs2_i/imm_i/ex_mem_i/mem_wb_i,
//        mux1_i/mux2_i/mux3_i, tag_i; out_valid_o/out_ready_i, res_o, tag_o, illegal_o, busy_o.
// Optional macro ZBB_CLMUL_EN adds the iterative clmul/clmulh/clmulr path.
module zbb_exec_pipe
  import zbb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 5,
  parameter int CLMUL_STEP = 4
) (
  input  logic             clk_25mhz,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0]       alu_op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  ex_mem_i,
  input  logic [XLEN-1:0]  mem_wb_i,
  input  logic [1:0]       mux1_i,
  input  logic [1:0]       mux2_i,
  input  logic             mux3_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  res_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o,
  output logic             busy_o
);

  localparam int CNTW = $clog2(XLEN) + 1;
  localparam int SHW  = $clog2(XLEN);
  localparam int NB   = XLEN / 8;

  if ((XLEN != 32 && XLEN != 64) || (XLEN % CLMUL_STEP) != 0) begin : g_bad_cfg
    $error("zbb_exec_pipe: XLEN must be 32/64 and divisible by CLMUL_STEP");
  end

  logic [XLEN-1:0]  w_op1, w_op2_pre, w_op2;
  logic             w_accept, w_s1_adv, w_op_done, w_busy;
  logic             r_s1_vld;
  logic [XLEN-1:0]  r_s1_op1, r_s1_op2;
  logic [4:0]       r_s1_opc;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_out_vld, r_ill;
  logic [XLEN-1:0]  r_res;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  w_res;
  logic             w_ill;

  // Operand selection
  always_comb begin
    case (mux1_i)
      SEL_RS:    w_op1 = rs1_i;
      SEL_MEMWB: w_op1 = mem_wb_i;
      SEL_EXMEM: w_op1 = ex_mem_i;
      default:   w_op1 = '0;
    endcase
    case (mux2_i)
      SEL_RS:    w_op2_pre = rs2_i;
      SEL_MEMWB: w_op2_pre = mem_wb_i;
      SEL_EXMEM: w_op2_pre = ex_mem_i;
      default:   w_op2_pre = '0;
    endcase
    w_op2 = mux3_i ? imm_i : w_op2_pre;
  end

`ifdef ZBB_CLMUL_EN
  logic              w_cl_done;
  logic [2*XLEN-1:0] w_prod;

  // The multiplier starts on the accept edge so its RUN cycles overlap S1 occupancy.
  zbb_clmul_iter #(.XLEN(XLEN), .STEP(CLMUL_STEP)) u_clmul (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .i_start   (w_accept && is_clmul(alu_op_i)),
    .i_ack     (w_s1_adv),
    .i_op1     (w_op1),
    .i_op2     (w_op2),
    .o_done    (w_cl_done),
    .o_busy    (w_busy),
    .o_prod    (w_prod)
  );
  assign w_op_done = is_clmul(r_s1_opc) ? w_cl_done : 1'b1;
`else
  assign w_busy    = 1'b0;
  assign w_op_done = 1'b1;
`endif

  assign w_s1_adv   = r_s1_vld && w_op_done && (!r_out_vld || out_ready_i);
  assign in_ready_o = (!r_s1_vld || w_s1_adv) && !w_busy;
  assign w_accept   = in_valid_i && in_ready_o;

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_op1 <= '0;
      r_s1_op2 <= '0;
      r_s1_opc <= OP_NOP;
      r_s1_tag <= '0;
    end else if (w_accept) begin
      r_s1_vld <= 1'b1;
      r_s1_op1 <= w_op1;
      r_s1_op2 <= w_op2;
      r_s1_opc <= alu_op_i;
      r_s1_tag <= tag_i;
    end else if (w_s1_adv) begin
      r_s1_vld <= 1'b0;
    end
  end

  // Bit-count datapath; later loop iterations take priority.
  logic [CNTW-1:0] w_clz, w_ctz, w_cpop;
  always_comb begin
    w_clz  = CNTW'(XLEN);
    w_ctz  = CNTW'(XLEN);
    w_cpop = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (r_s1_op1[i]) w_clz = CNTW'(XLEN - 1 - i);
      w_cpop = w_cpop + CNTW'(r_s1_op1[i]);
    end
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (r_s1_op1[i]) w_ctz = CNTW'(i);
    end
  end

  logic [SHW-1:0]    w_sh;
  logic [2*XLEN-1:0] w_rol_dbl, w_ror_dbl;
  logic [XLEN-1:0]   w_orc, w_rev;
  always_comb begin
    w_sh      = r_s1_op2[SHW-1:0];
    w_rol_dbl = {r_s1_op1, r_s1_op1} << w_sh;
    w_ror_dbl = {r_s1_op1, r_s1_op1} >> w_sh;
    w_orc     = '0;
    w_rev     = '0;
    for (int b = 0; b < NB; b++) begin
      w_orc[8*b +: 8] = (|r_s1_op1[8*b +: 8]) ? 8'hFF : 8'h00;
      w_rev[8*b +: 8] = r_s1_op1[8*(NB-1-b) +: 8];
    end
  end

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (r_s1_opc)
      OP_NOP:   w_res = '0;
      OP_CLZ:   w_res = {{(XLEN-CNTW){1'b0}}, w_clz};
      OP_CTZ:   w_res = {{(XLEN-CNTW){1'b0}}, w_ctz};
      OP_CPOP:  w_res = {{(XLEN-CNTW){1'b0}}, w_cpop};
      OP_MINU:  w_res = (r_s1_op1 < r_s1_op2) ? r_s1_op1 : r_s1_op2;
      OP_MAXU:  w_res = (r_s1_op1 > r_s1_op2) ? r_s1_op1 : r_s1_op2;
      OP_SEXTH: w_res = {{(XLEN-16){r_s1_op1[15]}}, r_s1_op1[15:0]};
      OP_SEXTB: w_res = {{(XLEN-8){r_s1_op1[7]}}, r_s1_op1[7:0]};
      OP_MAX:   w_res = ($signed(r_s1_op1) > $signed(r_s1_op2)) ? r_s1_op1 : r_s1_op2;
      OP_MIN:   w_res = ($signed(r_s1_op1) < $signed(r_s1_op2)) ? r_s1_op1 : r_s1_op2;
      OP_ZEXTH: w_res = {{(XLEN-16){1'b0}}, r_s1_op1[15:0]};
      OP_ROL:   w_res = w_rol_dbl[2*XLEN-1:XLEN];
      OP_ROR:   w_res = w_ror_dbl[XLEN-1:0];
      OP_ORCB:  w_res = w_orc;
      OP_REV8:  w_res = w_rev;
      OP_ANDN:  w_res = r_s1_op1 & ~r_s1_op2;
      OP_ORN:   w_res = r_s1_op1 | ~r_s1_op2;
      OP_XNOR:  w_res = ~(r_s1_op1 ^ r_s1_op2);
`ifdef ZBB_CLMUL_EN
      OP_CLMUL:  w_res = w_prod[XLEN-1:0];
      OP_CLMULH: w_res = w_prod[2*XLEN-1:XLEN];
      OP_CLMULR: w_res = w_prod[2*XLEN-2:XLEN-1];
`endif
      default:  w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_res     <= '0;
      r_tag     <= '0;
      r_ill     <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_vld <= 1'b1;
      r_res     <= w_res;
      r_tag     <= r_s1_tag;
      r_ill     <= w_ill;
    end else if (out_ready_i) begin
      r_out_vld <= 1'b0;
    end
  end

  assign out_valid_o = r_out_vld;
  assign res_o       = r_res;
  assign tag_o       = r_tag;
  assign illegal_o   = r_ill;
  assign busy_o      = w_busy;

endmodule

// File: tb/tb_zbb_exec_pipe.sv
module tb_zbb_exec_pipe;
  import zbb_pkg::*;

  logic        clk_25mhz = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [4:0]  alu_op_i = '0;
  logic [31:0] rs1_i = '0, rs2_i = '0, imm_i = '0;
  logic [31:0] ex_mem_i = 32'd7, mem_wb_i = 32'd9;
  logic [1:0]  mux1_i = '0, mux2_i = '0;
  logic        mux3_i = 1'b0;
  logic [4:0]  tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] res_o;
  logic [4:0]  tag_o;
  logic        illegal_o;
  logic        busy_o;

  zbb_exec_pipe #(.XLEN(32), .TAG_W(5), .CLMUL_STEP(4)) dut (
    .clk_25mhz  (clk_25mhz),
    .rst        (rst),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .alu_op_i   (alu_op_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .imm_i      (imm_i),
    .ex_mem_i   (ex_mem_i),
    .mem_wb_i   (mem_wb_i),
    .mux1_i     (mux1_i),
    .mux2_i     (mux2_i),
    .mux3_i     (mux3_i),
    .tag_i      (tag_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .res_o      (res_o),
    .tag_o      (tag_o),
    .illegal_o  (illegal_o),
    .busy_o     (busy_o)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [4:0]  tag_ctr = 5'd1;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", name);
  endtask

  // Output monitor: pops the scoreboard on every completed output handshake
  // and checks that a stalled output does not change.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_tag;
  always @(negedge clk_25mhz) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid_o) begin
        chk("stall_res_stable", {32'd0, res_o}, {32'd0, prev_res});
        chk("stall_tag_stable", {59'd0, tag_o}, {59'd0, prev_tag});
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_res   = res_o;
      prev_tag   = tag_o;
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res", {32'd0, res_o}, {32'd0, e.res});
          chk("tag", {59'd0, tag_o}, {59'd0, e.tag});
          chk("illegal", {63'd0, illegal_o}, {63'd0, e.ill});
        end
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [1:0] m1, input logic [1:0] m2,
                      input logic m3, input logic [31:0] exp_res, input logic exp_ill,
                      input logic push);
    bit accepted = 0;
    int waited = 0;
    alu_op_i = op; rs1_i = a; rs2_i = b; imm_i = imm;
    mux1_i = m1; mux2_i = m2; mux3_i = m3; tag_i = tag_ctr;
    in_valid_i = 1'b1;
    while (!accepted && waited < 64) begin
      @(negedge clk_25mhz);
      if (in_ready_o) begin
        accepted = 1;
        if (push) sb.push_back('{res: exp_res, tag: tag_ctr, ill: exp_ill});
      end
      @(posedge clk_25mhz);
      #1;
      waited++;
    end
    in_valid_i = 1'b0;
    tag_ctr = tag_ctr + 5'd1;
    if (!accepted) fail_now("accept_timeout");
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(posedge clk_25mhz);
      #1;
      waited++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    repeat (3) @(posedge clk_25mhz);
    #1 rst = 1'b0;
    @(negedge clk_25mhz);
    chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_res", {32'd0, res_o}, 64'd0);
    chk("rst_tag", {59'd0, tag_o}, 64'd0);
    chk("rst_illegal", {63'd0, illegal_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    @(posedge clk_25mhz);
    #1;

    // Single-cycle ops
    send(OP_CLZ,  32'h0000_1000, 32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'd19, 1'b0, 1'b1);
    send(OP_CTZ,  32'h0000_1000, 32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'd12, 1'b0, 1'b1);
    send(OP_CPOP, 32'hFFFF_FFFF, 32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'd32, 1'b0, 1'b1);
    send(OP_CLZ,  32'h0,         32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'd32, 1'b0, 1'b1);
    send(OP_CTZ,  32'h0,         32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'd32, 1'b0, 1'b1);
    send(OP_ROR,  32'h0000_0001, 32'd5, 32'd1, SEL_RS, SEL_RS, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    send(OP_ROL,  32'h8000_0001, 32'd4, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'h0000_0018, 1'b0, 1'b1);
    send(OP_ROR,  32'h1234_5678, 32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
    send(OP_ORCB, 32'h0001_0200, 32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'h00FF_FF00, 1'b0, 1'b1);
    send(OP_REV8, 32'h1122_3344, 32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'h4433_2211, 1'b0, 1'b1);
    send(OP_ANDN, 32'hFF,        32'h0F, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'hF0, 1'b0, 1'b1);
    send(OP_SEXTB, 32'h0000_0080, 32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b1);
    send(OP_XNOR, 32'hF0F0_0000, 32'h0F0F_FFFF, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    // Forwarding paths
    send(OP_MAXU, 32'd100, 32'd200, 32'd0, SEL_EXMEM, SEL_MEMWB, 1'b0, 32'd9, 1'b0, 1'b1);
    send(OP_MIN,  32'd55, 32'hFFFF_FFFD, 32'd0, SEL_ZERO, SEL_RS, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b1);
    // Illegal opcodes
    send(5'h0D, 32'hDEAD_BEEF, 32'd1, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'd0, 1'b1, 1'b1);
    send(5'h1F, 32'hDEAD_BEEF, 32'd1, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'd0, 1'b1, 1'b1);
    drain();

    // Backpressure: consumer stalls while four ops are offered back to back
    @(posedge clk_25mhz);
    #1 out_ready_i = 1'b0;
    fork
      begin
        send(OP_CPOP, 32'h0000_000F, 32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'd4, 1'b0, 1'b1);
        send(OP_ZEXTH, 32'hABCD_1234, 32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'h0000_1234, 1'b0, 1'b1);
        send(OP_SEXTH, 32'h0000_8001, 32'd0, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'hFFFF_8001, 1'b0, 1'b1);
        send(OP_ORN,  32'h0, 32'hFFFF_0000, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'h0000_FFFF, 1'b0, 1'b1);
      end
      begin
        repeat (3) @(posedge clk_25mhz);
        #1 out_ready_i = 1'b1;
      end
    join
    drain();

`ifdef ZBB_CLMUL_EN
    begin
      int edges = 0;
      bit seen = 0;
      alu_op_i = OP_CLMUL; rs1_i = 32'h3; rs2_i = 32'h3; mux1_i = SEL_RS; mux2_i = SEL_RS;
      mux3_i = 1'b0; tag_i = tag_ctr; in_valid_i = 1'b1;
      @(negedge clk_25mhz);
      chk("clmul_in_ready", {63'd0, in_ready_o}, 64'd1);
      sb.push_back('{res: 32'h5, tag: tag_ctr, ill: 1'b0});
      @(posedge clk_25mhz);
      #1 in_valid_i = 1'b0;
      tag_ctr = tag_ctr + 5'd1;
      edges = 1;
      while (!seen && edges < 40) begin
        @(negedge clk_25mhz);
        if (out_valid_o) seen = 1;
        else begin
          @(posedge clk_25mhz);
          edges++;
        end
      end
      chk("clmul_latency", 64'(edges), 64'd10);
    end
    drain();
    send(OP_CLMULH, 32'h8000_0000, 32'h2, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'h1, 1'b0, 1'b1);
    send(OP_CLMULR, 32'h8000_0000, 32'h2, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'h2, 1'b0, 1'b1);
    drain();
    // Reset in the middle of a clmul abandons it
    send(OP_CLMUL, 32'h7, 32'h7, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_25mhz);
    #1 rst = 1'b1;
    @(posedge clk_25mhz);
    #1 rst = 1'b0;
    @(negedge clk_25mhz);
    chk("midrst_busy", {63'd0, busy_o}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready_o}, 64'd1);
    begin
      bit any_out = 0;
      repeat (12) begin
        @(negedge clk_25mhz);
        if (out_valid_o) any_out = 1;
      end
      chk("midrst_no_output", {63'd0, any_out}, 64'd0);
    end
`else
    send(OP_CLMUL, 32'h3, 32'h3, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'd0, 1'b1, 1'b1);
    send(OP_CLMULR, 32'h3, 32'h3, 32'd0, SEL_RS, SEL_RS, 1'b0, 32'd0, 1'b1, 1'b1);
    drain();
    @(negedge clk_25mhz);
    chk("busy_tied_low", {63'd0, busy_o}, 64'd0);
`endif

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
